// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 raster constants for the VGA timing generator.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    // Defaults match the 25.175 MHz pixel rate produced by the NCO.
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam bit HS_POL_DEF   = 1'b0;
    localparam bit VS_POL_DEF   = 1'b0;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM and registered sync.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF,
    parameter bit POL    = 1'b0,
    localparam int TOTAL = ACTIVE + FP + SYNC + BP,
    localparam int CW    = $clog2(TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step,
    output logic [CW-1:0] next_count,
    output phase_e        next_phase,
    output logic          sync,
    output logic          wrap
);

    logic [CW-1:0] count;
    phase_e        phase;
    logic          sync_next;

    // Reset parks the axis on its last position so the first step lands on 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= CW'(TOTAL - 1);
            phase <= PH_BACK;
            sync  <= ~POL;
        end else if (step) begin
            count <= next_count;
            phase <= next_phase;
            sync  <= sync_next;
        end
    end

    always_comb begin
        wrap       = step && (count == CW'(TOTAL - 1));
        next_count = count;
        next_phase = phase;
        if (step) begin
            next_count = wrap ? '0 : count + CW'(1);
            if (next_count == CW'(ACTIVE + FP + SYNC))
                next_phase = PH_BACK;
            else if (next_count == CW'(ACTIVE + FP))
                next_phase = PH_SYNC;
            else if (next_count == CW'(ACTIVE))
                next_phase = PH_FRONT;
            else if (next_count == '0)
                next_phase = PH_ACTIVE;
        end
    end

    always_comb begin
        sync_next = (next_phase == PH_SYNC) ? POL : ~POL;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator stepped by the NCO pixel enable.
// Optional completed-frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit HS_POL   = HS_POL_DEF,
    parameter bit VS_POL   = VS_POL_DEF,
    localparam int XW = $clog2(H_ACTIVE),
    localparam int YW = $clog2(V_ACTIVE),
    localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);

    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    phase_e        h_phase_next;
    phase_e        v_phase_next;
    logic          h_wrap;
    logic          v_wrap;
    logic          de_next;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .step(pix_en),
        .next_count(h_next), .next_phase(h_phase_next),
        .sync(hsync), .wrap(h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .step(h_wrap & pix_en),
        .next_count(v_next), .next_phase(v_phase_next),
        .sync(vsync), .wrap(v_wrap)
    );

    always_comb begin
        de_next = (h_phase_next == PH_ACTIVE) && (v_phase_next == PH_ACTIVE);
    end

    // Outputs are taken from the next-state position so they line up with the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            de          <= de_next;
            x           <= de_next ? XW'(h_next) : '0;
            y           <= de_next ? YW'(v_next) : '0;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_cnt_q <= '0;
        else if (pix_en && v_wrap)
            frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule
